// File: rtl/add64_cla.sv
// 64-bit unsigned carry-lookahead adder with a registered {carry_out, S}.
// Lookahead runs in three levels (4-bit groups, 16-bit blocks, full word), with no ripple between groups.
module add64_cla #(
  parameter int N       = 64,
  parameter int GROUP_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         carry_in,
  output logic [N-1:0] S,
  output logic         carry_out
);

  localparam int NG = N / GROUP_W;  // first-level groups
  localparam int NB = NG / 4;       // second-level blocks

  // Combines four generate/propagate pairs into one group pair.
  // Returns {G, P}.
  function automatic logic [1:0] la_gp(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    logic pp;
    gg = g[3]
       | (p[3] & g[2])
       | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
    pp = &p;
    return {gg, pp};
  endfunction

  // Produces the three internal carries of a 4-wide lookahead unit as flat
  // sum-of-products from its carry-in. Returns {c3, c2, c1}.
  function automatic logic [2:0] la_carry(input logic [3:0] g, input logic [3:0] p,
                                          input logic cin);
    logic c1;
    logic c2;
    logic c3;
    c1 = g[0] | (p[0] & cin);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return {c3, c2, c1};
  endfunction

  logic [N-1:0]  w_g;
  logic [N-1:0]  w_p;
  logic [N-1:0]  w_c;
  logic [N-1:0]  w_sum;
  logic [NG-1:0] w_grp_g;
  logic [NG-1:0] w_grp_p;
  logic [NG-1:0] w_grp_cin;
  logic [NB-1:0] w_blk_g;
  logic [NB-1:0] w_blk_p;
  logic [NB-1:0] w_blk_cin;
  logic          w_all_g;
  logic          w_all_p;
  logic          w_cout;

  logic [N-1:0]  r_sum_p1;
  logic          r_cout_p1;

  // Stage p0: bit-level generate/propagate
  assign w_g = A & B;
  assign w_p = A ^ B;

  for (genvar gi = 0; gi < NG; gi++) begin : g_l1
    assign {w_grp_g[gi], w_grp_p[gi]} = la_gp(w_g[gi*4 +: 4], w_p[gi*4 +: 4]);
    assign w_c[gi*4]                  = w_grp_cin[gi];
    assign w_c[gi*4+1 +: 3]           = la_carry(w_g[gi*4 +: 4], w_p[gi*4 +: 4],
                                                 w_grp_cin[gi]);
  end

  for (genvar bi = 0; bi < NB; bi++) begin : g_l2
    assign {w_blk_g[bi], w_blk_p[bi]} = la_gp(w_grp_g[bi*4 +: 4], w_grp_p[bi*4 +: 4]);
    assign w_grp_cin[bi*4]            = w_blk_cin[bi];
    assign w_grp_cin[bi*4+1 +: 3]     = la_carry(w_grp_g[bi*4 +: 4], w_grp_p[bi*4 +: 4],
                                                 w_blk_cin[bi]);
  end

  // Top unit: only carry_in feeds it, so every carry in the tree resolves from c[0].
  assign {w_all_g, w_all_p} = la_gp(w_blk_g, w_blk_p);
  assign w_blk_cin[0]       = carry_in;
  assign w_blk_cin[3:1]     = la_carry(w_blk_g, w_blk_p, carry_in);
  assign w_cout             = w_all_g | (w_all_p & carry_in);

  assign w_sum = w_p ^ w_c;

  // Stage p1: registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_p1  <= '0;
      r_cout_p1 <= 1'b0;
    end else begin
      r_sum_p1  <= w_sum;
      r_cout_p1 <= w_cout;
    end
  end

  assign S         = r_sum_p1;
  assign carry_out = r_cout_p1;

endmodule

// File: tb/tb_add64_cla.sv
// Self-checking bench for add64_cla: directed corner cases, reset behaviour and
// back-to-back random operands compared against 65-bit behavioural addition.
module tb_add64_cla;

  logic        clk;
  logic        rst;
  logic [63:0] A;
  logic [63:0] B;
  logic        carry_in;
  logic [63:0] S;
  logic        carry_out;

  int checks = 0;
  int errors = 0;

  add64_cla dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .carry_in (carry_in),
    .S        (S),
    .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic ci);
    return {1'b0, a} + {1'b0, b} + {64'd0, ci};
  endfunction

  task automatic test_reset();
    rst = 1'b1; A = '1; B = '1; carry_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({carry_out, S} !== 65'd0) begin
        errors++;
        $display("FAIL reset_%0d got cout=%b S=%h want cout=0 S=0", i, carry_out, S);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [63:0] ta [5];
    logic [63:0] tb [5];
    logic        tc [5];
    logic [64:0] exp_r [5];
    ta[0] = 64'd0;                   tb[0] = 64'd0;          tc[0] = 1'b1;
    exp_r[0] = {1'b0, 64'd1};
    ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tb[1] = 64'd0;          tc[1] = 1'b1;
    exp_r[1] = {1'b1, 64'd0};
    ta[2] = 64'hFFFF_FFFF_FFFF_FFFF; tb[2] = 64'hFFFF_FFFF_FFFF_FFFF; tc[2] = 1'b1;
    exp_r[2] = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    ta[3] = 64'h0000_0000_FFFF_FFFF; tb[3] = 64'd1;          tc[3] = 1'b0;
    exp_r[3] = {1'b0, 64'h0000_0001_0000_0000};
    ta[4] = 64'h0000_0000_0000_FFFF; tb[4] = 64'd0;          tc[4] = 1'b1;
    exp_r[4] = {1'b0, 64'h0000_0000_0001_0000};
    for (int i = 0; i < 5; i++) begin
      A = ta[i]; B = tb[i]; carry_in = tc[i];
      @(posedge clk); #1;
      checks++;
      if ({carry_out, S} !== exp_r[i]) begin
        errors++;
        $display("FAIL directed_%0d got cout=%b S=%h want cout=%b S=%h",
                 i, carry_out, S, exp_r[i][64], exp_r[i][63:0]);
      end
    end
  endtask

  task automatic test_hold();
    logic [64:0] held;
    A = 64'h1234_5678_9ABC_DEF0; B = 64'hFEDC_BA98_7654_3210; carry_in = 1'b1;
    @(posedge clk); #1;
    held = ref_add(A, B, carry_in);
    A = 64'd7; B = 64'd9; carry_in = 1'b0;
    #3;
    checks++;
    if ({carry_out, S} !== held) begin
      errors++;
      $display("FAIL hold got cout=%b S=%h want cout=%b S=%h",
               carry_out, S, held[64], held[63:0]);
    end
  endtask

  task automatic test_back_to_back();
    int n_ok = 0, n_bad = 0, n_ovf = 0;
    logic [64:0] exp_r;
    for (int i = 0; i < 64; i++) begin
      case (i % 4)
        0: begin A = {$urandom, $urandom}; B = {$urandom, $urandom}; end
        1: begin A = {$urandom, $urandom}; B = ~A; end
        2: begin A = '1; B = {32'd0, $urandom}; end
        default: begin A = {$urandom, $urandom} | 64'hF0F0_0000_FFFF_0000;
                       B = {$urandom, $urandom}; end
      endcase
      carry_in = 1'($urandom_range(0, 1));
      exp_r = ref_add(A, B, carry_in);
      @(posedge clk); #1;
      checks++;
      if ({carry_out, S} !== exp_r) begin
        errors++; n_bad++;
        $display("FAIL random_%0d got cout=%b S=%h want cout=%b S=%h",
                 i, carry_out, S, exp_r[64], exp_r[63:0]);
      end else begin
        n_ok++;
      end
      if (exp_r[64]) n_ovf++;
    end
    $display("random: ok=%0d bad=%0d overflow=%0d", n_ok, n_bad, n_ovf);
  endtask

  task automatic test_mid_reset();
    logic [64:0] exp_r;
    A = '1; B = 64'd5; carry_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({carry_out, S} !== 65'd0) begin
      errors++;
      $display("FAIL mid_reset got cout=%b S=%h want cout=0 S=0", carry_out, S);
    end
    rst = 1'b0;
    A = 64'h8000_0000_0000_0000; B = 64'h8000_0000_0000_0001; carry_in = 1'b0;
    exp_r = ref_add(A, B, carry_in);
    @(posedge clk); #1;
    checks++;
    if ({carry_out, S} !== exp_r) begin
      errors++;
      $display("FAIL after_reset got cout=%b S=%h want cout=%b S=%h",
               carry_out, S, exp_r[64], exp_r[63:0]);
    end
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; carry_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
